wb_led_bank: RTL and testbench
==============================

// Module: wb_led_bank
// PURPOSE
//  Parametrised Wishbone slave driving a bank of NLEDS debug LEDs, with a small register map.
//  Provides direct on/off control, per-LED blink and a read-only ID word.
//  Read ack delay is programmable.
//  Sits on the peripheral Wishbone bus; outputs go straight to board LED pins.
// PARAMETERS
//  NLEDS      8             number of LED outputs (1..32)
//  READ_WAIT  2             wait cycles between read accept and ack (0..15)
//  PRESC_W    24            width of blink period register/counter (1..32)
//  RESET_VAL  {NLEDS{1'b0}} value of OUT register (and led_o) after reset
//  ID_VAL     32'h1ED0_0001 constant returned by ID register
// PORTS
//  sys_clk    in   1      system clock; all logic on rising edge
//  sys_rst    in   1      synchronous active-high reset
//  wb_adr_i   in   32     byte address; only [3:2] decoded
//  wb_dat_i   in   32     write data
//  wb_dat_o   out  32     read data, registered
//  wb_cyc_i   in   1      bus cycle
//  wb_stb_i   in   1      strobe
//  wb_we_i    in   1      1 = write
//  wb_ack_o   out  1      single-cycle acknowledge
//  led_o      out  NLEDS  LED drive, registered
// BEHAVIOUR
//  Register map (adr[3:2]):
//    0 OUT    rw  [NLEDS-1:0] LED state
//    1 BLINK  rw  [NLEDS-1:0] per-LED blink mask
//    2 PERIOD rw  [PRESC_W-1:0] half-period in sys_clk cycles
//    3 ID     ro  ID_VAL; writes ignored
//  Unused read bits return 0.
//  Reset (sync): FSM=IDLE, wb_ack_o=0, wb_dat_o=0, OUT=RESET_VAL, BLINK=0, PERIOD=0,
//    blink counter=0, phase=0, led_o=RESET_VAL.
//  FSM IDLE/WAIT/ACK:
//    - IDLE: on cyc&stb&we, write register at that edge, go ACK.
//    - IDLE: on cyc&stb&!we, capture read data into wb_dat_o at that edge,
//      go WAIT if READ_WAIT>0, else ACK.
//    - WAIT: 4-bit counter loaded with READ_WAIT-1, decrements; at 0 go ACK.
//    - ACK: wb_ack_o=1 (decoded from state) for exactly one cycle, then IDLE.
//  Latency: write ack 1 cycle after accept; read ack READ_WAIT+1 cycles after accept.
//  Request dropped (cyc or stb low) while in WAIT: transaction completes regardless;
//    the ack is ignored by the master. No abort.
//  cyc&stb still high in the cycle after ACK is treated as a new request.
//  Reset mid-transaction returns to IDLE next edge; no ack is issued.
//  Blink: when PERIOD!=0, the counter counts down from PERIOD-1; at 0 it reloads and
//    toggles phase. PERIOD==0 holds phase=0.
//  Any PERIOD write clears counter and phase on the same edge.
//  led_o <= OUT & ~(BLINK & {NLEDS{phase}}); blinking LEDs with OUT=1 flash, OUT=0 stay off.
// CONFIGURATION
//  WB_LED_BANK_BLINK_EN defined: BLINK/PERIOD registers, counter and phase behave as above.
//  Undefined: BLINK/PERIOD read 0, writes acked but ignored, no counter logic,
//    led_o <= OUT.
// STRUCTURE
//  Package wb_led_bank_pkg:
//    - register index localparams REG_OUT=0, REG_BLINK=1, REG_PERIOD=2, REG_ID=3
//    - FSM state encodings S_IDLE/S_WAIT/S_ACK (2 bits)
//  Sub-module wb_led_bank_blink (PRESC_W):
//    - inputs sys_clk, sys_rst, period, period_wr; output phase
//    - instantiated only under WB_LED_BANK_BLINK_EN
// TESTING
//  1. Write 0xA5 to adr 0x0 (NLEDS=8) -> ack 1 cycle after accept; led_o=0xA5 next cycle.
//  2. Read adr 0xC, READ_WAIT=2 -> ack 3 cycles after accept, wb_dat_o=32'h1ED0_0001;
//     READ_WAIT=0 -> ack after 1 cycle.
//  3. OUT=0xFF, BLINK=0x0F, PERIOD=4 -> led_o low nibble toggles every 4 cycles,
//     high nibble steady 1; write PERIOD=0 -> led_o=0xFF steady.
//  4. Write adr 0xC with 0 -> acked, ID still reads 0x1ED00001;
//     readback of OUT/BLINK/PERIOD matches written values with upper bits 0.
//  5. Assert sys_rst while FSM in WAIT -> no ack, led_o=RESET_VAL, FSM IDLE next edge;
//     next read completes normally.
//  6. Build without WB_LED_BANK_BLINK_EN -> BLINK/PERIOD write acked,
//     read 0, led_o equals OUT.

Source files
------------

// File: rtl/wb_led_bank_pkg.sv
// Shared definitions for the Wishbone LED bank: register indices and bus FSM states.
package wb_led_bank_pkg;

    localparam logic [1:0] REG_OUT    = 2'd0;
    localparam logic [1:0] REG_BLINK  = 2'd1;
    localparam logic [1:0] REG_PERIOD = 2'd2;
    localparam logic [1:0] REG_ID     = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/wb_led_bank_blink.sv
// Blink phase generator: square wave whose half-period is `period` sys_clk cycles.
// A period of zero parks the phase low; a period write restarts the count.
module wb_led_bank_blink #(
    parameter int unsigned PRESC_W = 24
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [PRESC_W-1:0] period,
    input  logic               period_wr,
    output logic               phase
);

    logic [PRESC_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || period_wr) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (period == '0) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == '0) begin
            cnt   <= period - PRESC_W'(1);
            phase <= ~phase;
        end else begin
            cnt <= cnt - PRESC_W'(1);
        end
    end

endmodule

// File: rtl/wb_led_bank.sv
// Wishbone slave driving NLEDS debug LEDs: OUT/BLINK/PERIOD/ID registers, programmable read wait.
// Blink support is built only when WB_LED_BANK_BLINK_EN is defined.
module wb_led_bank
    import wb_led_bank_pkg::*;
#(
    parameter int unsigned      NLEDS     = 8,
    parameter int unsigned      READ_WAIT = 2,
    parameter int unsigned      PRESC_W   = 24,
    parameter logic [NLEDS-1:0] RESET_VAL = '0,
    parameter logic [31:0]      ID_VAL    = 32'h1ED0_0001
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [31:0]      wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    output logic             wb_ack_o,
    output logic [NLEDS-1:0] led_o
);

    localparam bit         HAS_WAIT  = (READ_WAIT > 0);
    localparam logic [3:0] WAIT_LOAD = 4'(HAS_WAIT ? READ_WAIT - 1 : 0);

    state_t           state, state_nxt;
    logic [3:0]       wait_cnt;
    logic [NLEDS-1:0] out_reg;
    logic [NLEDS-1:0] led_nxt;
    logic [31:0]      rdata;
    logic [1:0]       reg_sel;
    logic             accept, wr_en, rd_en;
    logic             unused_bits;

    assign reg_sel     = wb_adr_i[3:2];
    assign accept      = (state == S_IDLE) && wb_cyc_i && wb_stb_i;
    assign wr_en       = accept && wb_we_i;
    assign rd_en       = accept && !wb_we_i;
    assign wb_ack_o    = (state == S_ACK);
    assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i};

`ifdef WB_LED_BANK_BLINK_EN
    logic [NLEDS-1:0]   blink_reg;
    logic [PRESC_W-1:0] period_reg;
    logic               phase;
    logic               period_wr;

    assign period_wr = wr_en && (reg_sel == REG_PERIOD);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            blink_reg  <= '0;
            period_reg <= '0;
        end else begin
            if (wr_en && reg_sel == REG_BLINK) blink_reg <= wb_dat_i[NLEDS-1:0];
            if (period_wr)                     period_reg <= wb_dat_i[PRESC_W-1:0];
        end
    end

    wb_led_bank_blink #(
        .PRESC_W(PRESC_W)
    ) u_blink (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .period   (period_reg),
        .period_wr(period_wr),
        .phase    (phase)
    );

    assign led_nxt = out_reg & ~(blink_reg & {NLEDS{phase}});
`else
    assign led_nxt = out_reg;
`endif

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_OUT:    rdata[NLEDS-1:0] = out_reg;
`ifdef WB_LED_BANK_BLINK_EN
            REG_BLINK:  rdata[NLEDS-1:0] = blink_reg;
            REG_PERIOD: rdata[PRESC_W-1:0] = period_reg;
`endif
            REG_ID:     rdata = ID_VAL;
            default:    rdata = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i)
                    state_nxt = (wb_we_i || !HAS_WAIT) ? S_ACK : S_WAIT;
            end
            S_WAIT:  if (wait_cnt == 4'd0) state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            wb_dat_o <= '0;
            out_reg  <= RESET_VAL;
            led_o    <= RESET_VAL;
        end else begin
            state <= state_nxt;
            led_o <= led_nxt;
            if (rd_en) begin
                wb_dat_o <= rdata;
                wait_cnt <= WAIT_LOAD;
            end else if (state == S_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (wr_en && reg_sel == REG_OUT) out_reg <= wb_dat_i[NLEDS-1:0];
        end
    end

endmodule

// File: tb/tb_wb_led_bank.sv
// Scoreboard bench for wb_led_bank: the driver queues expected acks, a monitor checks them.
module tb_wb_led_bank;
    import wb_led_bank_pkg::*;

    localparam logic [31:0] ID = 32'h1ED0_0001;
`ifdef WB_LED_BANK_BLINK_EN
    localparam logic [31:0] EXP_BLINK  = 32'h0000_000F;
    localparam logic [31:0] EXP_PERIOD = 32'h00FF_FFFF;
`else
    localparam logic [31:0] EXP_BLINK  = 32'h0;
    localparam logic [31:0] EXP_PERIOD = 32'h0;
`endif

    typedef struct {
        logic        is_read;
        logic [31:0] data;
        int          accept;
        int          lat;
        string       name;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [31:0] wb_adr = '0, wb_dat_i = '0, wb_dat_o;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0, wb_ack;
    logic [7:0]  led;

    logic        cyc0 = 1'b0, stb0 = 1'b0, ack0;
    logic [31:0] adr0 = 32'hC, dat_i0 = '0, dat_o0;
    logic        we0 = 1'b0;
    logic [7:0]  led0;

    exp_t exp_q[$];
    int   cyc_cnt = 0, issued = 0, acks_done = 0;
    int   n_pass = 0, n_total = 0;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc_cnt++;

    wb_led_bank #(.READ_WAIT(2)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
        .wb_ack_o(wb_ack), .led_o(led)
    );

    wb_led_bank #(.READ_WAIT(0)) dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .wb_adr_i(adr0), .wb_dat_i(dat_i0),
        .wb_dat_o(dat_o0), .wb_cyc_i(cyc0), .wb_stb_i(stb0), .wb_we_i(we0),
        .wb_ack_o(ack0), .led_o(led0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: the master samples ack at the next rising edge, hence cyc_cnt+1.
    always begin
        exp_t e;
        @(negedge sys_clk);
        if (wb_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL spurious_ack: ack seen at cycle %0d with nothing outstanding", cyc_cnt);
            end else begin
                e = exp_q.pop_front();
                check({e.name, " latency"}, 32'(cyc_cnt + 1 - e.accept), 32'(e.lat));
                if (e.is_read) check({e.name, " data"}, wb_dat_o, e.data);
                acks_done++;
            end
        end
    end

    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [31:0] exp, input string name);
        exp_t e;
        @(negedge sys_clk);
        e.is_read = !we;
        e.data    = exp;
        e.accept  = cyc_cnt + 1;
        e.lat     = we ? 1 : 3;
        e.name    = name;
        exp_q.push_back(e);
        issued++;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = dat;
        @(negedge sys_clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        for (int i = 0; i < 32 && acks_done != issued; i++) @(negedge sys_clk);
        if (acks_done != issued) begin
            n_total++;
            $display("FAIL %s: no ack within 32 cycles", name);
            void'(exp_q.pop_front());
            acks_done = issued;
        end
    endtask

    initial begin
        logic [7:0] s [12];

        repeat (3) @(negedge sys_clk);
        check("rst ack", {31'b0, wb_ack}, 32'h0);
        check("rst dat_o", wb_dat_o, 32'h0);
        check("rst led", {24'b0, led}, 32'h0);
        sys_rst = 1'b0;

        // READ_WAIT=0 instance: ack already visible in the cycle after accept.
        @(negedge sys_clk);
        cyc0 = 1'b1; stb0 = 1'b1;
        @(negedge sys_clk);
        cyc0 = 1'b0; stb0 = 1'b0;
        check("rw0 ack", {31'b0, ack0}, 32'h1);
        check("rw0 data", dat_o0, ID);
        @(negedge sys_clk);
        check("rw0 ack single", {31'b0, ack0}, 32'h0);

        xfer(1'b1, 32'h0, 32'h0000_00A5, 32'h0, "wr OUT");
        @(negedge sys_clk);
        check("led after OUT", {24'b0, led}, 32'hA5);
        xfer(1'b0, 32'h0, 32'h0, 32'hA5, "rd OUT");
        xfer(1'b0, 32'hC, 32'h0, ID, "rd ID");
        xfer(1'b1, 32'hC, 32'h0, 32'h0, "wr ID");
        xfer(1'b0, 32'hC, 32'h0, ID, "rd ID after wr");

        xfer(1'b1, 32'h0, 32'hFFFF_FFA5, 32'h0, "wr OUT wide");
        xfer(1'b0, 32'h0, 32'h0, 32'hA5, "rd OUT wide");
        xfer(1'b1, 32'h4, 32'hFFFF_FF0F, 32'h0, "wr BLINK");
        xfer(1'b0, 32'h4, 32'h0, EXP_BLINK, "rd BLINK");
        xfer(1'b1, 32'h8, 32'hFFFF_FFFF, 32'h0, "wr PERIOD");
        xfer(1'b0, 32'h8, 32'h0, EXP_PERIOD, "rd PERIOD");

        xfer(1'b1, 32'h0, 32'hFF, 32'h0, "wr OUT FF");
        xfer(1'b1, 32'h4, 32'h0F, 32'h0, "wr BLINK 0F");
        xfer(1'b1, 32'h8, 32'h4, 32'h0, "wr PERIOD 4");
        for (int i = 0; i < 12; i++) begin
            @(negedge sys_clk);
            s[i] = led;
        end
`ifdef WB_LED_BANK_BLINK_EN
        for (int i = 0; i < 8; i++) check("blink half-period", {24'b0, s[i] ^ s[i+4]}, 32'h0F);
        for (int i = 0; i < 12; i++) check("blink high nibble", {28'b0, s[i][7:4]}, 32'hF);
`else
        for (int i = 0; i < 12; i++) check("led equals OUT", {24'b0, s[i]}, 32'hFF);
`endif
        xfer(1'b1, 32'h8, 32'h0, 32'h0, "wr PERIOD 0");
        repeat (2) @(negedge sys_clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            check("led steady", {24'b0, led}, 32'hFF);
        end

        // Reset while the read sits in WAIT: the ack must never appear.
        @(negedge sys_clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'hC;
        @(negedge sys_clk);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check("mid rst ack", {31'b0, wb_ack}, 32'h0);
        check("mid rst led", {24'b0, led}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            check("post rst ack", {31'b0, wb_ack}, 32'h0);
        end
        xfer(1'b0, 32'hC, 32'h0, ID, "rd ID after rst");
        xfer(1'b0, 32'h0, 32'h0, 32'h0, "rd OUT after rst");

        repeat (2) @(negedge sys_clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish (passed %0d of %0d)", n_pass, n_total);
        $fatal(1);
    end

endmodule
